stepper_phase_sequencer: RTL and testbench
==========================================

// Module: stepper_phase_sequencer
// PURPOSE
//  Consumes move commands (step count + direction) from the forklift motion controller.
//  Drives a 4-wire stepper through its coil phase sequence at a fixed step rate set by an
//  internal divider. Reports busy/done and tracks absolute position in steps.
//  Sits between the motion control FSM and the coil driver pins.
// PARAMETERS
//  STEP_DIV  10000000  clk cycles per step; legal range >= 2
//  STEPS_W   16        width of the cmd_steps field
//  POS_W     32        width of the signed position counter
// PORTS
//  clk        in   1        system clock
//  reset      in   1        reset, synchronous, active-high
//  cmd_valid  in   1        move command present
//  cmd_ready  out  1        block can accept a command; high exactly when in IDLE
//  cmd_steps  in   STEPS_W  number of steps to move (unsigned)
//  cmd_dir    in   1        1 = forward (index +1), 0 = reverse (index -1)
//  abort      in   1        stop the current move at the next clock edge
//  coil       out  4        coil drive pattern {D,C,B,A}
//  busy       out  1        move in progress (RUN state)
//  done       out  1        one-cycle pulse on move completion
//  pos        out  POS_W    signed absolute position in steps
// BEHAVIOUR
//  - Reset values: coil=4'b0000 (de-energised), busy=0, done=0, cmd_ready=1, pos=0,
//    phase index=0, divider=0, state=IDLE. Reset mid-move aborts the move with no done pulse.
//  - Handshake: a command is accepted on a clock edge where cmd_valid & cmd_ready.
//    cmd_steps and cmd_dir are latched at that edge; later changes are ignored.
//  - States: IDLE, RUN.
//    IDLE -> RUN: accept with cmd_steps != 0. remaining<=cmd_steps, divider<=0,
//      coil<=table[index] (energise/hold at the current phase), busy<=1.
//    IDLE, accept with cmd_steps == 0: stay in IDLE. done=1 for the next cycle only;
//      coil and pos are unchanged.
//    RUN: divider counts 0..STEP_DIV-1. At divider==STEP_DIV-1: divider<=0,
//      index <= index +/- 1 (modulo the table length), coil<=table[new index],
//      pos <= pos +/- 1, remaining <= remaining - 1.
//    RUN -> IDLE on the step where remaining becomes 0: busy<=0, done<=1 for one cycle.
//      The first step occurs STEP_DIV cycles after acceptance; step k occurs at k*STEP_DIV.
//    RUN, abort=1: go to IDLE at the next edge. No step on that edge, even if the divider
//      is at its terminal count. done stays 0; coil holds its pattern; pos keeps the steps taken.
//    IDLE, abort=1: ignored. If cmd_valid is also high, the command is accepted.
//  - Back-to-back moves: cmd_ready is high in the cycle where done=1, so a held cmd_valid
//    is accepted at that edge. The phase index carries over between moves.
//  - After a completed or aborted move, coil holds the last pattern (holding torque).
//    Only reset de-energises the coils.
//  - pos wraps in two's complement at POS_W bits. remaining never underflows.
//  - Full-step table (two-phase-on), index 0..3: 0011, 0110, 1100, 1001.
// CONFIGURATION
//  HALF_STEP_EN defined: 8-entry half-step table with a 3-bit index, index 0..7:
//    0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Each step advances one entry;
//    pos still counts +/-1 per entry.
//  HALF_STEP_EN undefined: 4-entry full-step table above with a 2-bit index.
//  Ports and timing are identical in both builds.
// TESTING (STEP_DIV=4, full-step unless noted)
//  1. reset; cmd steps=3 dir=1 -> coil=0011 one cycle after accept; 0110/1100/1001 at
//     +4/+8/+12 cycles; done=1 for one cycle at +12; busy 1->0 at +12; pos=3.
//  2. From reset, steps=3 dir=0 -> coil 0011, then 1001, 1100, 0110;
//     pos=32'hFFFF_FFFD; done pulses once.
//  3. steps=0 -> done=1 one cycle after accept; busy never 1; coil=0000; pos=0.
//  4. steps=10 dir=1, abort asserted 2 cycles after step 1 -> IDLE next edge; done never 1;
//     pos=1; coil holds 0110; cmd_ready=1.
//  5. cmd_valid held high with two queued commands (2 fwd, 1 rev) -> second command accepted
//     on the done cycle of the first; final pos=1; no cycle gap in cmd_ready use.
//  6. reset asserted mid-move -> next cycle coil=0000, pos=0, busy=0, done=0, cmd_ready=1.
//     HALF_STEP_EN build: steps=2 dir=1 -> coil 0001, 0011, 0010; pos=2.

Source files
------------

// File: rtl/stepper_phase_sequencer.sv
// Stepper phase sequencer: accepts move commands and walks a 4-wire stepper through its coil table.
// Optional HALF_STEP_EN selects the 8-entry half-step table instead of the 4-entry full-step table.
module stepper_phase_sequencer #(
    parameter int unsigned STEP_DIV = 10000000,
    parameter int unsigned STEPS_W  = 16,
    parameter int unsigned POS_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               cmd_dir,
    input  logic               abort,
    output logic [3:0]         coil,
    output logic               busy,
    output logic               done,
    output logic [POS_W-1:0]   pos
);

`ifdef HALF_STEP_EN
    localparam int unsigned IDX_W = 3;
`else
    localparam int unsigned IDX_W = 2;
`endif
    localparam int unsigned DIV_W = $clog2(STEP_DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic [STEPS_W-1:0] rem_q, rem_n;
    logic               dir_q, dir_n;
    logic [3:0]         coil_n;
    logic [POS_W-1:0]   pos_n;
    logic               done_n;
    logic               busy_n;
    logic               ready_n;

    // Coil pattern {D,C,B,A} for a phase index
    function automatic logic [3:0] phase_pattern(input logic [IDX_W-1:0] i);
        logic [3:0] p;
`ifdef HALF_STEP_EN
        case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            default: p = 4'b1001;
        endcase
`else
        case (i)
            2'd0:    p = 4'b0011;
            2'd1:    p = 4'b0110;
            2'd2:    p = 4'b1100;
            default: p = 4'b1001;
        endcase
`endif
        return p;
    endfunction

    // Next-state and datapath
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        div_n   = div_q;
        rem_n   = rem_q;
        dir_n   = dir_q;
        coil_n  = coil;
        pos_n   = pos;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_steps == STEPS_W'(0)) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        rem_n   = cmd_steps;
                        dir_n   = cmd_dir;
                        div_n   = DIV_W'(0);
                        coil_n  = phase_pattern(idx_q);
                    end
                end
            end
            RUN: begin
                // Abort wins over a step due on the same edge
                if (abort) begin
                    state_n = IDLE;
                end else if (div_q == DIV_W'(STEP_DIV - 1)) begin
                    div_n  = DIV_W'(0);
                    idx_n  = dir_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
                    coil_n = phase_pattern(idx_n);
                    pos_n  = dir_q ? pos + POS_W'(1) : pos - POS_W'(1);
                    rem_n  = rem_q - STEPS_W'(1);
                    if (rem_q == STEPS_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n  = (state_n == RUN);
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            coil      <= 4'b0000;
            pos       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            div_q     <= div_n;
            rem_q     <= rem_n;
            dir_q     <= dir_n;
            coil      <= coil_n;
            pos       <= pos_n;
            done      <= done_n;
            busy      <= busy_n;
            cmd_ready <= ready_n;
        end
    end

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Bench for stepper_phase_sequencer: directed moves plus random traffic against a
// closed-form position model (steps taken = elapsed cycles / STEP_DIV). Honours HALF_STEP_EN.
module tb_stepper_phase_sequencer;

    localparam int unsigned STEP_DIV = 4;
    localparam int unsigned STEPS_W  = 16;
    localparam int unsigned POS_W    = 32;
`ifdef HALF_STEP_EN
    localparam int TLEN = 8;
    logic [3:0] tbl [0:7] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
    localparam int TLEN = 4;
    logic [3:0] tbl [0:3] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [STEPS_W-1:0] cmd_steps;
    logic               cmd_dir;
    logic               abort;
    logic [3:0]         coil;
    logic               busy;
    logic               done;
    logic [POS_W-1:0]   pos;

    stepper_phase_sequencer #(
        .STEP_DIV(STEP_DIV),
        .STEPS_W (STEPS_W),
        .POS_W   (POS_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps),
        .cmd_dir  (cmd_dir),
        .abort    (abort),
        .coil     (coil),
        .busy     (busy),
        .done     (done),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    // Reference model: a move is described by its start cycle, length, direction and start position
    int          cyc = 0;
    bit          m_run, m_done, m_en, m_dir;
    int          m_t0, m_n, m_idx, m_idx0;
    logic [31:0] m_pos, m_pos0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic [15:0] s,
                                input logic d, input logic a);
        int taken;
        cyc++;
        if (r) begin
            m_run = 0; m_done = 0; m_en = 0; m_pos = '0; m_idx = 0;
        end else if (!m_run) begin
            m_done = 0;
            if (v) begin
                if (s == 16'd0) m_done = 1;
                else begin
                    m_run = 1; m_t0 = cyc; m_n = int'(s); m_dir = d;
                    m_pos0 = m_pos; m_idx0 = m_idx; m_en = 1;
                end
            end
        end else begin
            m_done = 0;
            if (a) m_run = 0;
            else begin
                taken = (cyc - m_t0) / int'(STEP_DIV);
                if (taken > m_n) taken = m_n;
                m_pos = m_dir ? m_pos0 + 32'(taken) : m_pos0 - 32'(taken);
                m_idx = m_dir ? (m_idx0 + taken) % TLEN : (m_idx0 + TLEN - (taken % TLEN)) % TLEN;
                if (taken == m_n) begin m_run = 0; m_done = 1; end
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare every output after the edge
    task automatic tick(input logic r, input logic v, input logic [15:0] s,
                        input logic d, input logic a);
        reset = r; cmd_valid = v; cmd_steps = s; cmd_dir = d; abort = a;
        model_update(r, v, s, d, a);
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
        check("coil",      64'(coil),      64'(m_en ? tbl[m_idx] : 4'b0000));
        check("busy",      64'(busy),      64'(m_run));
        check("done",      64'(done),      64'(m_done));
        check("cmd_ready", 64'(cmd_ready), 64'(!m_run));
        check("pos",       64'(pos),       64'(m_pos));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        done_seen = 0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; abort = 1'b0;
        do_reset();
        check("reset_coil", 64'(coil), 64'(4'b0000));
        check("reset_ready", 64'(cmd_ready), 64'd1);

        // Forward 3 steps
        tick(1'b0, 1'b1, 16'd3, 1'b1, 1'b0);
        idle(14);
        check("fwd3_pos", 64'(pos), 64'd3);
        check("fwd3_done_once", 64'(done_seen), 64'd1);

        // Reverse 3 steps from reset wraps pos negative
        do_reset();
        tick(1'b0, 1'b1, 16'd3, 1'b0, 1'b0);
        idle(14);
        check("rev3_pos", 64'(pos), 64'(32'hFFFF_FFFD));
        check("rev3_done_once", 64'(done_seen), 64'd1);

        // Zero-step command
        do_reset();
        tick(1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
        check("zero_done", 64'(done), 64'd1);
        idle(3);
        check("zero_coil", 64'(coil), 64'(4'b0000));
        check("zero_pos", 64'(pos), 64'd0);

        // Abort two cycles after the first step
        do_reset();
        tick(1'b0, 1'b1, 16'd10, 1'b1, 1'b0);
        idle(5);
        tick(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        idle(8);
        check("abort_pos", 64'(pos), 64'd1);
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd1);

        // Held cmd_valid: second command accepted on the done cycle of the first
        do_reset();
        tick(1'b0, 1'b1, 16'd2, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 16'd1, 1'b0, 1'b0);
        check("b2b_busy", 64'(busy), 64'd1);
        idle(6);
        check("b2b_pos", 64'(pos), 64'd1);
        check("b2b_done_twice", 64'(done_seen), 64'd2);

        // Reset mid-move
        tick(1'b0, 1'b1, 16'd5, 1'b1, 1'b0);
        idle(6);
        tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        check("midreset_coil", 64'(coil), 64'(4'b0000));
        check("midreset_pos", 64'(pos), 64'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            tick(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) == 0),
                 16'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 24) == 0));
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
